stopwatch_controller: RTL and testbench

//  Sequences a cascaded chain of modulo digit counters that forms an MM:SS.hh stopwatch.
//  A prescaler derives a 1/100 s tick from clk. An FSM handles start/stop, lap-freeze and clear.

---
 rtl/stopwatch_controller.sv | 136 +++++++++++++
 tb/tb_stopwatch_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : stopwatch_controller                                       |
// | Function : MM:SS.hh stopwatch with run/pause, lap freeze and overflow |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module stopwatch_controller #(
   parameter int TICK_DIV = 500000,
   parameter int DIV_BITS = 19
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   output logic [23:0] time_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        tick,
   output logic        overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_OVF   = 2'd3
   } state_t;

   localparam logic [DIV_BITS-1:0] c_tick_last = DIV_BITS'(TICK_DIV - 1);
   // Digit order, LSB first: hundredths, tenths, s1, s10, m1, m10
   localparam logic [23:0]         c_digit_max = 24'h595999;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DIV_BITS-1:0] r_presc;
   logic [23:0]         r_digits;
   logic [23:0]         w_digits_nxt;
   logic [23:0]         r_lap_reg;
   logic                r_lap_active;
   logic                w_tick;
   logic                w_at_top;
   logic                w_carry;
   logic                w_enter_ovf;
   logic                w_lap_ok;

   assign w_tick      = (r_state == S_RUN) && (r_presc == c_tick_last);
   assign w_at_top    = (r_digits == c_digit_max);
   assign w_enter_ovf = (r_state != S_OVF) && (w_state_nxt == S_OVF);
   assign w_lap_ok    = lap && !start_stop && !clear &&
                        ((r_state == S_RUN) || (r_state == S_PAUSE));

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start_stop) w_state_nxt = S_RUN;
            S_RUN: begin
               if (start_stop)             w_state_nxt = S_PAUSE;
               else if (w_tick && w_at_top) w_state_nxt = S_OVF;
            end
            S_PAUSE: if (start_stop) w_state_nxt = S_RUN;
            S_OVF:   w_state_nxt = S_OVF;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Ripple carry through all six digits; the final tick at 59:59.99 holds
   always_comb begin
      w_digits_nxt = r_digits;
      w_carry      = w_tick && !w_at_top;
      for (int i = 0; i < 6; i++) begin
         if (w_carry) begin
            if (r_digits[4*i +: 4] == c_digit_max[4*i +: 4]) begin
               w_digits_nxt[4*i +: 4] = 4'd0;
            end else begin
               w_digits_nxt[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
               w_carry                = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc  <= '0;
         r_digits <= '0;
      end else if (clear) begin
         r_presc  <= '0;
         r_digits <= '0;
      end else begin
         if (r_state == S_RUN) begin
            r_presc <= (r_presc == c_tick_last) ? '0 : r_presc + DIV_BITS'(1);
         end
         r_digits <= w_digits_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lap_active <= 1'b0;
         r_lap_reg    <= '0;
      end else if (clear) begin
         r_lap_active <= 1'b0;
         r_lap_reg    <= '0;
      end else if (w_enter_ovf) begin
         r_lap_active <= 1'b0;
      end else if (w_lap_ok) begin
         if (r_lap_active) begin
            r_lap_active <= 1'b0;
         end else begin
            r_lap_active <= 1'b1;
            r_lap_reg    <= r_digits;
         end
      end
   end

   assign time_bcd   = r_lap_active ? r_lap_reg : r_digits;
   assign running    = (r_state == S_RUN);
   assign overflow   = (r_state == S_OVF);
   assign lap_active = r_lap_active;
   assign tick       = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_stopwatch_controller                                    |
// | Function : directed stimulus with a centisecond-count reference model |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_stopwatch_controller;

   localparam int TD  = 4;
   localparam int DB  = 2;
   localparam int TOP = 359999;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_stop = 1'b0;
   logic        lap = 1'b0;
   logic        clear = 1'b0;
   logic [23:0] time_bcd;
   logic        running;
   logic        lap_active;
   logic        tick;
   logic        overflow;

   int checks = 0;
   int failures = 0;
   int tick_seen = 0;
   bit cmp_on = 1'b0;

   // Reference model: elapsed time as a plain centisecond count
   int m_cent = 0;
   int m_presc = 0;
   int m_lapval = 0;
   bit m_run = 1'b0;
   bit m_pause = 1'b0;
   bit m_ovf = 1'b0;
   bit m_lap = 1'b0;
   bit mt_tick;
   bit mt_top;
   bit mt_enter_ovf;
   int mt_snap;

   always #5 clk = ~clk;

   stopwatch_controller #(.TICK_DIV(TD), .DIV_BITS(DB)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .time_bcd   (time_bcd),
      .running    (running),
      .lap_active (lap_active),
      .tick       (tick),
      .overflow   (overflow)
   );

   function automatic logic [23:0] to_bcd(input int c);
      int mm, ss, hh;
      mm = c / 6000;
      ss = (c / 100) % 60;
      hh = c % 100;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(hh / 10), 4'(hh % 10)};
   endfunction

   task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cent = 0; m_presc = 0; m_lapval = 0;
         m_run = 0; m_pause = 0; m_ovf = 0; m_lap = 0;
      end else begin
         mt_tick = m_run && (m_presc == TD - 1);
         mt_snap = m_cent;
         if (clear) begin
            m_cent = 0; m_presc = 0; m_lapval = 0;
            m_run = 0; m_pause = 0; m_ovf = 0; m_lap = 0;
         end else begin
            mt_top = 1'b0;
            mt_enter_ovf = 1'b0;
            if (mt_tick) begin
               if (m_cent == TOP) mt_top = 1'b1;
               else               m_cent++;
            end
            if (m_run) m_presc = (m_presc + 1) % TD;
            if (start_stop) begin
               if (!m_ovf) begin
                  if (m_run) begin m_run = 0; m_pause = 1; end
                  else       begin m_run = 1; m_pause = 0; end
               end
            end else begin
               if (mt_top) begin
                  m_run = 0; m_ovf = 1; mt_enter_ovf = 1;
               end
               if (lap && !mt_enter_ovf && (m_run || m_pause)) begin
                  if (m_lap) m_lap = 0;
                  else begin m_lap = 1; m_lapval = mt_snap; end
               end
            end
            if (mt_enter_ovf) m_lap = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (tick === 1'b1) tick_seen++;
      if (cmp_on && failures < 20) begin
         check("model_time",     time_bcd,   m_lap ? to_bcd(m_lapval) : to_bcd(m_cent));
         check("model_running",  running,    m_run);
         check("model_lap",      lap_active, m_lap);
         check("model_tick",     tick,       m_run && (m_presc == TD - 1));
         check("model_overflow", overflow,   m_ovf);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input bit ss, input bit lp, input bit cl);
      start_stop = ss; lap = lp; clear = cl;
      @(negedge clk);
      start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
   endtask

   initial begin
      int budget;
      cycles(2);
      check("rst_time", time_bcd, 24'h0);
      check("rst_outs", {running, lap_active, tick, overflow}, 24'h0);
      reset = 1'b1;
      cmp_on = 1'b1;

      // 1: idle
      tick_seen = 0;
      cycles(10);
      check("t1_time", time_bcd, 24'h000000);
      check("t1_running", running, 1'b0);
      check("t1_ticks", 24'(tick_seen), 24'd0);

      // 2: ten ticks in 40 cycles
      tick_seen = 0;
      pulse(1, 0, 0);
      cycles(40);
      check("t2_ticks", 24'(tick_seen), 24'd10);
      check("t2_time", time_bcd, 24'h000010);
      check("t2_running", running, 1'b1);

      // 3: pause one cycle before the tick is due
      pulse(0, 0, 1);
      pulse(1, 0, 0);
      cycles(38);
      pulse(1, 0, 0);
      check("t3_pause_time", time_bcd, 24'h000009);
      check("t3_pause_run", running, 1'b0);
      tick_seen = 0;
      cycles(20);
      check("t3_hold_time", time_bcd, 24'h000009);
      check("t3_hold_ticks", 24'(tick_seen), 24'd0);
      pulse(1, 0, 0);
      check("t3_resume_tick", tick, 1'b1);
      check("t3_resume_time", time_bcd, 24'h000009);
      cycles(1);
      check("t3_after_tick", time_bcd, 24'h000010);

      // 4: lap freeze and release
      cycles(60);
      check("t4_pre_lap", time_bcd, 24'h000025);
      pulse(0, 1, 0);
      check("t4_lap_on", lap_active, 1'b1);
      cycles(40);
      check("t4_frozen", time_bcd, 24'h000025);
      pulse(0, 1, 0);
      check("t4_released", time_bcd, 24'h000035);
      check("t4_lap_off", lap_active, 1'b0);

      // 5: run to overflow with lap engaged; entering OVF drops the freeze
      pulse(0, 1, 0);
      check("t5_lap_on", time_bcd, 24'h000035);
      budget = 0;
      while (overflow !== 1'b1 && budget < 1600000) begin
         @(negedge clk);
         budget++;
      end
      check("t5_ovf_time", time_bcd, 24'h595999);
      check("t5_ovf_flag", overflow, 1'b1);
      check("t5_ovf_run", running, 1'b0);
      check("t5_ovf_lap", lap_active, 1'b0);
      pulse(1, 0, 0);
      cycles(8);
      check("t5_ss_ignored", time_bcd, 24'h595999);
      check("t5_ss_ovf", overflow, 1'b1);
      pulse(0, 1, 0);
      check("t5_lap_ignored", lap_active, 1'b0);
      pulse(0, 0, 1);
      check("t5_clear_time", time_bcd, 24'h000000);
      check("t5_clear_flags", {running, overflow}, 24'h0);

      // 6: clear beats start_stop; prescaler restarts from zero
      pulse(1, 0, 0);
      cycles(6);
      pulse(1, 0, 1);
      check("t6_clear_run", running, 1'b0);
      check("t6_clear_time", time_bcd, 24'h000000);
      pulse(1, 0, 0);
      cycles(2);
      check("t6_no_early_tick", tick, 1'b0);
      cycles(1);
      check("t6_first_tick", tick, 1'b1);
      cycles(16);
      #2 reset = 1'b0;
      #1;
      check("t6_async_time", time_bcd, 24'h000000);
      check("t6_async_outs", {running, lap_active, tick, overflow}, 24'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick_seen = 0;
      cycles(10);
      check("t6_post_rst_time", time_bcd, 24'h000000);
      check("t6_post_rst_run", running, 1'b0);
      check("t6_post_rst_ticks", 24'(tick_seen), 24'd0);

      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
